// File: rtl/hevc_luma_subpel_fir.sv
// hevc_luma_subpel_fir
// Three-stage pipelined HEVC luma sub-pixel interpolation filter (8-tap) with
// valid/ready flow control, HEVC rounding, output clipping and a clip counter.
//
// Ports
//   clock        rising-edge clock
//   reset_L      synchronous active-low reset
//   in_valid     input window valid
//   in_ready     block can accept a window this cycle (= !stall)
//   frac         0 full-pel, 1 quarter, 2 half, 3 three-quarter
//   inputPixels  taps 0..7, tap k at [k*BIT_DEPTH +: BIT_DEPTH], unsigned
//   out_valid    subPixel valid
//   out_ready    downstream accepts subPixel this cycle
//   subPixel     filtered, rounded, clipped sample
//   sat_count    number of delivered samples that were clipped (wraps)
module hevc_luma_subpel_fir #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned SATCNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               frac,
  input  logic [8*BIT_DEPTH-1:0]   inputPixels,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_DEPTH-1:0]     subPixel,
  output logic [SATCNT_W-1:0]      sat_count
);

  // Worst-case sum is +88 * max pixel, which fits in BIT_DEPTH+8 signed bits.
  localparam int unsigned SUM_W = BIT_DEPTH + 8;

  // Coefficient rows, one signed byte per tap, tap 0 in the low byte.
  localparam logic [63:0] Coefs [4] = '{
    64'h0000_0000_4000_0000,  // 0, 0, 0, 64, 0, 0, 0, 0
    64'h0001_FB11_3AF6_04FF,  // -1, 4, -10, 58, 17, -5, 1, 0
    64'hFF04_F528_28F5_04FF,  // -1, 4, -11, 40, 40, -11, 4, -1
    64'hFF04_F63A_11FB_0100   // 0, 1, -5, 17, 58, -10, 4, -1
  };

  localparam logic signed [SUM_W-1:0] RoundOfs = SUM_W'(32);
  localparam logic signed [SUM_W-1:0] MaxPix   = SUM_W'((1 << BIT_DEPTH) - 1);

  logic stall;

  // Stage 1: products
  logic                    s1_valid_q;
  logic signed [SUM_W-1:0] prod_d [8];
  logic signed [SUM_W-1:0] prod_q [8];

  // Stage 2: sum
  logic                    s2_valid_q;
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;

  // Stage 3: rounded and clipped output
  logic                    out_valid_q;
  logic [BIT_DEPTH-1:0]    sub_pixel_d;
  logic [BIT_DEPTH-1:0]    sub_pixel_q;
  logic                    clipped_d;
  logic                    clipped_q;
  logic signed [SUM_W-1:0] rnd_sum;
  logic signed [SUM_W-1:0] rnd;

  logic [SATCNT_W-1:0]     sat_count_q;

  // A full output register that is not being taken freezes the whole pipe.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    logic [63:0] row;
    logic signed [SUM_W-1:0] pix_ext;
    logic signed [SUM_W-1:0] coef_ext;
    row = Coefs[frac];
    for (int k = 0; k < 8; k++) begin
      pix_ext   = $signed(SUM_W'(inputPixels[k*BIT_DEPTH +: BIT_DEPTH]));
      coef_ext  = SUM_W'($signed(row[k*8 +: 8]));
      prod_d[k] = pix_ext * coef_ext;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 8; k++) begin
      sum_d = sum_d + prod_q[k];
    end
  end

  always_comb begin
    rnd_sum     = sum_q + RoundOfs;
    rnd         = rnd_sum >>> 6;
    sub_pixel_d = rnd[BIT_DEPTH-1:0];
    clipped_d   = 1'b0;
    if (rnd < 0) begin
      sub_pixel_d = '0;
      clipped_d   = 1'b1;
    end else if (rnd > MaxPix) begin
      sub_pixel_d = '1;
      clipped_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        prod_q[k] <= '0;
      end
      sum_q       <= '0;
      sub_pixel_q <= '0;
      clipped_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q  <= in_valid;
        prod_q      <= prod_d;
        s2_valid_q  <= s1_valid_q;
        sum_q       <= sum_d;
        out_valid_q <= s2_valid_q;
        sub_pixel_q <= sub_pixel_d;
        clipped_q   <= clipped_d;
      end
      // Counted on the transfer itself, so a stalled sample is counted once.
      if (out_valid_q && out_ready && clipped_q) begin
        sat_count_q <= sat_count_q + SATCNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign subPixel  = sub_pixel_q;
  assign sat_count = sat_count_q;

endmodule
